multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port opcode, input, 6 bits: IR[31:26], held stable by the datapath from DECODE until the return to FETCH.
REQ-004 The block SHALL have the port funct, input, 6 bits: IR[5:0], with the same stability as opcode.
REQ-005 The block SHALL have the port Zflag, input, 1 bit: the ALU zero flag, combinational from the current alu_op.
REQ-006 The block SHALL have the port alu_op, output, 4 bits: ALU operation code. The encodings are 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 NOR and 0111 SLT.
REQ-007 The block SHALL have the port alu_src_a, output, 1 bit: 0 selects PC, 1 selects register A.
REQ-008 The block SHALL have the port alu_src_b, output, 2 bits: 00 selects register B, 01 selects constant 4, 10 selects sign-extended imm, 11 selects sign-extended imm shifted left by 2.
REQ-009 The block SHALL have the outputs pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst and mem_to_reg, each 1 bit, as datapath strobes and selects.
REQ-010 The block SHALL have the port pc_source, output, 2 bits: 00 selects ALU result, 01 selects ALUOut, 10 selects the jump target.
REQ-011 The block SHALL have the port state, output, 4 bits: the current state code.
REQ-012 The block SHALL have the port illegal, output, 1 bit: a one-cycle pulse on an unsupported instruction.
REQ-013 The block SHALL have the port retired, output, 32 bits: the count of completed instructions.

Function
REQ-014 The states SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10 and JUMP=11; codes 12-15 SHALL go to FETCH on the next cycle.
REQ-015 Outputs SHALL be decoded from the state only, except pc_en in BRANCH. Every output not listed for a state SHALL be 0.
REQ-016 FETCH SHALL drive mem_read=1, ir_write=1, alu_src_b=01, alu_op=0010, pc_en=1 and pc_source=00, then go to DECODE.
REQ-017 DECODE SHALL drive alu_src_b=11 and alu_op=0010, then branch on opcode: 000000 to EXEC, 100011 or 101011 to MEMADR, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP.
REQ-018 In DECODE, any other opcode, or opcode 000000 with funct outside {100000,100010,100100,100101,100111,101010}, SHALL pulse illegal for that cycle and go to FETCH without incrementing retired.
REQ-019 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=0010, then go to MEMRD when opcode is 100011, else to MEMWR.
REQ-020 MEMRD SHALL drive mem_read=1 and iord=1, then go to MEMWB.
REQ-021 MEMWB SHALL drive reg_write=1 and mem_to_reg=1 with reg_dst=0, then go to FETCH.
REQ-022 MEMWR SHALL drive mem_write=1 and iord=1, then go to FETCH.
REQ-023 EXEC SHALL drive alu_src_a=1 and alu_src_b=00, then go to ALUWB.
REQ-024 EXEC SHALL map funct to alu_op as 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100 and 101010→0111.
REQ-025 ALUWB SHALL drive reg_write=1 and reg_dst=1, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=0110 and pc_source=01, with pc_en=Zflag (combinational), then go to FETCH.
REQ-027 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=0010, then go to ADDIWB. ADDIWB SHALL drive reg_write=1 with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-028 JUMP SHALL drive pc_source=10 and pc_en=1, then go to FETCH.
REQ-029 retired SHALL increment by 1 on each clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 Instruction latencies in cycles SHALL be: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.

Reset
REQ-031 When rst_n=0 the block SHALL immediately, independent of clk, set state to FETCH and retired to 0 and clear illegal. The outputs SHALL then show FETCH decoding.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction without incrementing retired. The first rising edge after rst_n rises SHALL execute FETCH.

Verification
REQ-033 The bench SHALL cover lw (opcode 100011): the state sequence SHALL be 0,1,2,3,4,0, mem_to_reg=1 in state 4, and retired SHALL go from 0 to 1 after 5 cycles.
REQ-034 The bench SHALL cover R-type with funct 101010: in EXEC alu_op SHALL be 0111, in ALUWB reg_dst=1 and reg_write=1, and the latency SHALL be 4 cycles.
REQ-035 The bench SHALL cover beq twice: with Zflag=1, pc_en=1 and pc_source=01 in BRANCH; with Zflag=0, pc_en=0. Both cases SHALL take 3 cycles and increment retired.
REQ-036 The bench SHALL cover opcode 111111 and also opcode 000000 with funct 000001: illegal SHALL be 1 for exactly one cycle in DECODE, the next state SHALL be FETCH, and retired SHALL be unchanged.
REQ-037 The bench SHALL drive rst_n low while in MEMRD: state SHALL become 0 asynchronously and retired 0. After release, FETCH outputs SHALL be mem_read=1, ir_write=1 and pc_en=1.
REQ-038 The bench SHALL preload retired=0xFFFFFFFF by forcing it, then run j (000010): retired SHALL become 0x00000000 after 3 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl : control FSM for a multicycle MIPS-subset datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        Zflag,
   output logic [3:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        pc_en,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] C_OP_RTYPE = 6'b000000;
   localparam logic [5:0] C_OP_LW    = 6'b100011;
   localparam logic [5:0] C_OP_SW    = 6'b101011;
   localparam logic [5:0] C_OP_BEQ   = 6'b000100;
   localparam logic [5:0] C_OP_ADDI  = 6'b001000;
   localparam logic [5:0] C_OP_J     = 6'b000010;

   localparam logic [3:0] C_ALU_ADD = 4'b0010;
   localparam logic [3:0] C_ALU_SUB = 4'b0110;
   localparam logic [3:0] C_ALU_AND = 4'b0000;
   localparam logic [3:0] C_ALU_OR  = 4'b0001;
   localparam logic [3:0] C_ALU_NOR = 4'b1100;
   localparam logic [3:0] C_ALU_SLT = 4'b0111;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_retired;
   logic        w_funct_ok;
   logic [3:0]  w_funct_alu;
   logic        w_retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_retired <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
      end
   end

   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = C_ALU_ADD;
      case (funct)
         6'b100000: w_funct_alu = C_ALU_ADD;
         6'b100010: w_funct_alu = C_ALU_SUB;
         6'b100100: w_funct_alu = C_ALU_AND;
         6'b100101: w_funct_alu = C_ALU_OR;
         6'b100111: w_funct_alu = C_ALU_NOR;
         6'b101010: w_funct_alu = C_ALU_SLT;
         default:   w_funct_ok  = 1'b0;
      endcase
   end

   // Every terminal state returns to FETCH, so leaving it is the retire event.
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
         default:                                               w_retire = 1'b0;
      endcase
   end

   always_comb begin
      w_next     = S_FETCH;
      alu_op     = 4'b0000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      pc_source  = 2'b00;
      illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = C_ALU_ADD;
            pc_en     = 1'b1;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = C_ALU_ADD;
            case (opcode)
               C_OP_RTYPE: begin
                  if (w_funct_ok) begin
                     w_next = S_EXEC;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               C_OP_LW, C_OP_SW: w_next  = S_MEMADR;
               C_OP_BEQ:         w_next  = S_BRANCH;
               C_OP_ADDI:        w_next  = S_ADDIEX;
               C_OP_J:           w_next  = S_JUMP;
               default:          illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = C_ALU_ADD;
            w_next    = (opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            w_next   = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = w_funct_alu;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = C_ALU_SUB;
            pc_source = 2'b01;
            pc_en     = Zflag;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = C_ALU_ADD;
            w_next    = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_en     = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule
`default_nettype wire
